// File: rtl/id_alu_issue.sv
// id_alu_issue: RV32I decode-and-issue stage in front of the ALU.
// Decodes an instruction plus its register-file operands and presents
// registered ALU operands/control and side-band fields through a 2-entry
// skid buffer (main output register + one skid register).
//
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   flush                 : synchronous discard of both buffer entries
//   in_valid / in_ready   : upstream handshake (instr, rs1Data, rs2Data)
//   out_valid / out_ready : downstream (EX) handshake
//   dataA, dataB          : ALU operands
//   func, aluOp           : ALU function code and op class
//   imm                   : sign-extended immediate (branch offset for B-type)
//   rd                    : destination register (0 when regWrite=0)
//   regWrite, memRead, memWrite, isBranch, illegal : side-band control
module id_alu_issue #(
  parameter int unsigned width = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [width-1:0] rs1Data,
  input  logic [width-1:0] rs2Data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [width-1:0] dataA,
  output logic [width-1:0] dataB,
  output logic [3:0]       func,
  output logic [2:0]       aluOp,
  output logic [width-1:0] imm,
  output logic [4:0]       rd,
  output logic             regWrite,
  output logic             memRead,
  output logic             memWrite,
  output logic             isBranch,
  output logic             illegal
);

  typedef struct packed {
    logic [width-1:0] dataA;
    logic [width-1:0] dataB;
    logic [width-1:0] imm;
    logic [3:0]       func;
    logic [2:0]       aluOp;
    logic [4:0]       rd;
    logic             regWrite;
    logic             memRead;
    logic             memWrite;
    logic             isBranch;
    logic             illegal;
  } entry_t;

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} state_t;

  state_t r_state;
  entry_t r_main;
  entry_t r_skid;
  logic   r_out_valid;

  entry_t           w_dec;
  logic [2:0]       w_f3;
  logic [2:0]       w_remap;
  logic             w_remap_ok;
  logic             w_legal;
  logic [width-1:0] w_immI;
  logic [width-1:0] w_immS;
  logic [width-1:0] w_immB;
  logic             w_accept;
  logic             w_drain;
  logic             w_unused_rs;

  // rs1/rs2 index fields are resolved by the register file upstream.
  assign w_unused_rs = ^instr[24:15];

  assign w_f3   = instr[14:12];
  assign w_immI = {{(width-12){instr[31]}}, instr[31:20]};
  assign w_immS = {{(width-12){instr[31]}}, instr[31:25], instr[11:7]};
  assign w_immB = {{(width-13){instr[31]}}, instr[31], instr[7],
                   instr[30:25], instr[11:8], 1'b0};

  // f3 -> ALU code remap for register/immediate ALU ops.
  always_comb begin
    w_remap    = 3'd0;
    w_remap_ok = 1'b1;
    unique case (w_f3)
      3'b000:  w_remap = 3'd0;
      3'b100:  w_remap = 3'd6;
      3'b110:  w_remap = 3'd4;
      3'b111:  w_remap = 3'd7;
      default: w_remap_ok = 1'b0;
    endcase
  end

  always_comb begin
    w_dec       = '0;
    w_dec.dataA = rs1Data;
    w_dec.dataB = rs2Data;
    w_legal     = 1'b0;
    unique case (instr[6:0])
      7'b0110011: begin
        // instr[30] selects sub; only meaningful for f3=000.
        w_legal        = w_remap_ok && (!instr[30] || (w_f3 == 3'b000));
        w_dec.aluOp    = 3'b010;
        w_dec.func     = {instr[30], w_remap};
        w_dec.regWrite = 1'b1;
      end
      7'b0010011: begin
        w_legal        = w_remap_ok;
        w_dec.aluOp    = 3'b010;
        w_dec.func     = {1'b0, w_remap};
        w_dec.dataB    = w_immI;
        w_dec.imm      = w_immI;
        w_dec.regWrite = 1'b1;
      end
      7'b0000011: begin
        w_legal        = 1'b1;
        w_dec.dataB    = w_immI;
        w_dec.imm      = w_immI;
        w_dec.memRead  = 1'b1;
        w_dec.regWrite = 1'b1;
      end
      7'b0100011: begin
        w_legal        = 1'b1;
        w_dec.dataB    = w_immS;
        w_dec.imm      = w_immS;
        w_dec.memWrite = 1'b1;
      end
      7'b1100011: begin
        // Legal branch f3: 000, 001, 100, 101.
        w_legal        = (w_f3[1] == 1'b0);
        w_dec.aluOp    = 3'b001;
        w_dec.func     = {1'b0, w_f3};
        w_dec.imm      = w_immB;
        w_dec.isBranch = 1'b1;
      end
      default: w_legal = 1'b0;
    endcase
    if (!w_legal) begin
      w_dec.illegal  = 1'b1;
      w_dec.aluOp    = 3'b111;
      w_dec.func     = 4'b0000;
      w_dec.dataB    = rs2Data;
      w_dec.imm      = '0;
      w_dec.regWrite = 1'b0;
      w_dec.memRead  = 1'b0;
      w_dec.memWrite = 1'b0;
      w_dec.isBranch = 1'b0;
    end
    w_dec.rd = w_dec.regWrite ? instr[11:7] : 5'd0;
  end

  assign in_ready = !reset && (r_state != S_FULL);
  assign w_accept = in_valid && in_ready && !flush;
  assign w_drain  = r_out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_state     <= S_EMPTY;
      r_main      <= '0;
      r_skid      <= '0;
      r_out_valid <= 1'b0;
    end else begin
      unique case (r_state)
        S_EMPTY: begin
          if (w_accept) begin
            r_main      <= w_dec;
            r_out_valid <= 1'b1;
            r_state     <= S_ONE;
          end
        end
        S_ONE: begin
          if (w_accept && w_drain) begin
            r_main <= w_dec;
          end else if (w_accept) begin
            r_skid  <= w_dec;
            r_state <= S_FULL;
          end else if (w_drain) begin
            r_out_valid <= 1'b0;
            r_state     <= S_EMPTY;
          end
        end
        S_FULL: begin
          if (w_drain) begin
            r_main  <= r_skid;
            r_state <= S_ONE;
          end
        end
        default: r_state <= S_EMPTY;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign dataA     = r_main.dataA;
  assign dataB     = r_main.dataB;
  assign func      = r_main.func;
  assign aluOp     = r_main.aluOp;
  assign imm       = r_main.imm;
  assign rd        = r_main.rd;
  assign regWrite  = r_main.regWrite;
  assign memRead   = r_main.memRead;
  assign memWrite  = r_main.memWrite;
  assign isBranch  = r_main.isBranch;
  assign illegal   = r_main.illegal;

endmodule

// File: tb/tb_id_alu_issue.sv
// Testbench for id_alu_issue: directed scenarios followed by random traffic,
// checked against a queue-based reference model of the issue stage.
module tb_id_alu_issue;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic        in_ready, out_valid;
  logic [31:0] instr, rs1Data, rs2Data;
  logic [31:0] dataA, dataB, imm;
  logic [3:0]  func;
  logic [2:0]  aluOp;
  logic [4:0]  rd;
  logic        regWrite, memRead, memWrite, isBranch, illegal;

  always #5 clk = ~clk;

  id_alu_issue #(.width(32)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .rs1Data(rs1Data), .rs2Data(rs2Data),
    .out_valid(out_valid), .out_ready(out_ready),
    .dataA(dataA), .dataB(dataB), .func(func), .aluOp(aluOp),
    .imm(imm), .rd(rd), .regWrite(regWrite), .memRead(memRead),
    .memWrite(memWrite), .isBranch(isBranch), .illegal(illegal)
  );

  typedef struct {
    logic [31:0] dA, dB, imm;
    logic [3:0]  func;
    logic [2:0]  op;
    logic [4:0]  rd;
    logic        rw, mr, mw, br, ill;
    logic        is_r;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  logic last_reset = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference decode, straight from the opcode table.
  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] a,
                                      input logic [31:0] b);
    exp_t        e;
    int          remap_tab[8] = '{0, -1, -1, -1, 6, -1, 4, 7};
    int          f3;
    int          code;
    int          immI, immS, immB;
    logic [11:0] s12;
    logic [12:0] b13;
    logic        ok;
    f3   = int'(ins[14:12]);
    code = remap_tab[f3];
    immI = $signed(ins[31:20]);
    s12  = {ins[31:25], ins[11:7]};
    immS = $signed(s12);
    b13  = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    immB = $signed(b13);
    e = '{dA: a, dB: b, imm: 32'd0, func: 4'd0, op: 3'd0, rd: 5'd0,
          rw: 1'b0, mr: 1'b0, mw: 1'b0, br: 1'b0, ill: 1'b0, is_r: 1'b0};
    ok = 1'b0;
    case (ins[6:0])
      7'h33: begin
        ok = (code >= 0) && (ins[30] == 1'b0 || f3 == 0);
        e.op = 3'd2; e.func = 4'(code) + (ins[30] ? 4'd8 : 4'd0);
        e.rw = 1'b1; e.is_r = 1'b1;
      end
      7'h13: begin
        ok = (code >= 0);
        e.op = 3'd2; e.func = 4'(code); e.dB = immI; e.imm = immI; e.rw = 1'b1;
      end
      7'h03: begin ok = 1'b1; e.dB = immI; e.imm = immI; e.mr = 1'b1; e.rw = 1'b1; end
      7'h23: begin ok = 1'b1; e.dB = immS; e.imm = immS; e.mw = 1'b1; end
      7'h63: begin
        ok = (f3 == 0 || f3 == 1 || f3 == 4 || f3 == 5);
        e.op = 3'd1; e.func = 4'(f3); e.imm = immB; e.br = 1'b1;
      end
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      e.ill = 1'b1; e.op = 3'd7; e.func = 4'd0;
      e.rw = 1'b0; e.mr = 1'b0; e.mw = 1'b0; e.br = 1'b0;
    end
    e.rd = e.rw ? ins[11:7] : 5'd0;
    return e;
  endfunction

  task automatic model_edge();
    bit drain, accept;
    last_reset = reset;
    if (reset || flush) begin
      q.delete();
    end else begin
      drain  = (q.size() > 0) && out_ready;
      accept = in_valid && (q.size() < 2);
      if (drain) void'(q.pop_front());
      if (accept) q.push_back(ref_decode(instr, rs1Data, rs2Data));
    end
  endtask

  task automatic check_outputs();
    exp_t e;
    chk("in_ready", 32'(in_ready), 32'(!reset && q.size() < 2));
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    if (q.size() > 0) begin
      e = q[0];
      chk("dataA", dataA, e.dA);
      if (!e.ill) chk("dataB", dataB, e.dB);
      if (!e.ill && !e.is_r) chk("imm", imm, e.imm);
      chk("func", 32'(func), 32'(e.func));
      chk("aluOp", 32'(aluOp), 32'(e.op));
      chk("rd", 32'(rd), 32'(e.rd));
      chk("flags", {27'd0, regWrite, memRead, memWrite, isBranch, illegal},
          {27'd0, e.rw, e.mr, e.mw, e.br, e.ill});
    end else if (last_reset) begin
      chk("rst_fields", dataA | dataB | imm | 32'(func) | 32'(aluOp) | 32'(rd), 32'd0);
      chk("rst_flags", {27'd0, regWrite, memRead, memWrite, isBranch, illegal}, 32'd0);
    end
  endtask

  task automatic cyc(input logic iv, input logic [31:0] ins, input logic [31:0] a,
                     input logic [31:0] b, input logic ordy, input logic fl,
                     input logic rst);
    in_valid = iv; instr = ins; rs1Data = a; rs2Data = b;
    out_ready = ordy; flush = fl; reset = rst;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [6:0]  ops[5] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63};
    int          k;
    w = $urandom;
    k = $urandom_range(0, 5);
    if (k < 5) w[6:0] = ops[k];
    if (k == 0) w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
    return w;
  endfunction

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    instr = '0; rs1Data = '0; rs2Data = '0;
    @(negedge clk);
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // add, sub, or back-to-back
    cyc(1, 32'h002081B3, 5, 7, 1, 0, 0);
    chk("add_aluOp", 32'(aluOp), 32'd2);
    chk("add_func", 32'(func), 32'd0);
    chk("add_dataA", dataA, 32'd5);
    chk("add_dataB", dataB, 32'd7);
    chk("add_rd", 32'(rd), 32'd3);
    chk("add_rw", 32'(regWrite), 32'd1);
    cyc(1, 32'h402081B3, 9, 4, 1, 0, 0);
    chk("sub_func", 32'(func), 32'd8);
    cyc(1, 32'h0020E1B3, 9, 4, 1, 0, 0);
    chk("or_func", 32'(func), 32'd4);
    chk("or_valid", 32'(out_valid), 32'd1);

    // addi -1, beq +8
    cyc(1, 32'hFFF00093, 0, 3, 1, 0, 0);
    chk("addi_dataB", dataB, 32'hFFFFFFFF);
    chk("addi_imm", imm, 32'hFFFFFFFF);
    cyc(1, 32'h00208463, 1, 1, 1, 0, 0);
    chk("beq_aluOp", 32'(aluOp), 32'd1);
    chk("beq_imm", imm, 32'd8);
    chk("beq_br", 32'(isBranch), 32'd1);
    chk("beq_rd", 32'(rd), 32'd0);
    cyc(0, 0, 0, 0, 1, 0, 0);

    // stall: A, B captured, C held off, then ordered drain
    cyc(1, 32'h002081B3, 32'h11, 1, 0, 0, 0);
    cyc(1, 32'h002081B3, 32'h22, 1, 0, 0, 0);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    cyc(1, 32'h002081B3, 32'h33, 1, 0, 0, 0);
    chk("stall_hold_A", dataA, 32'h11);
    cyc(1, 32'h002081B3, 32'h33, 1, 1, 0, 0);
    chk("drain_B", dataA, 32'h22);
    cyc(1, 32'h002081B3, 32'h33, 1, 1, 0, 0);
    chk("drain_C", dataA, 32'h33);
    cyc(0, 0, 0, 0, 1, 0, 0);
    chk("drained_empty", 32'(out_valid), 32'd0);

    // flush from FULL with in_valid and out_ready asserted
    cyc(1, 32'h00000013, 32'h44, 0, 0, 0, 0);
    cyc(1, 32'h00000013, 32'h55, 0, 0, 0, 0);
    cyc(1, 32'h00000013, 32'h66, 0, 1, 1, 0);
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    cyc(0, 0, 0, 0, 1, 0, 0);

    // illegal encodings, then reset mid-stream
    cyc(1, 32'h0000007F, 3, 3, 1, 0, 0);
    chk("ill_opc", 32'(illegal), 32'd1);
    chk("ill_aluOp", 32'(aluOp), 32'd7);
    chk("ill_writes", {29'd0, regWrite, memRead, memWrite}, 32'd0);
    cyc(1, 32'h0020A1B3, 3, 3, 0, 0, 0);
    chk("slt_ill", 32'(illegal), 32'd1);
    cyc(1, 32'h002081B3, 8, 8, 0, 0, 1);
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_dataA", dataA, 32'd0);
    cyc(0, 0, 0, 0, 0, 0, 0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      cyc(logic'($urandom_range(0, 3) != 0), rand_instr(), $urandom, $urandom,
          logic'($urandom_range(0, 9) < 6), logic'($urandom_range(0, 39) == 0),
          logic'($urandom_range(0, 99) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
